// File: rtl/grng_coef_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | grng_coef_sched: credit-based round-robin scheduler sharing one           |
// | coefficient ROM between NREQ ICDF channels. Option: GRNG_COEF_SCHED_PRIO0_EN |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module grng_coef_sched #(
  parameter int NREQ       = 4,
  parameter int ID_W       = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [7*NREQ-1:0] req_seg,
  output logic [NREQ-1:0]   req_ready,
  output logic              en_coef,
  output logic [6:0]        segment,
  input  logic [20:0]       rom_coef0,
  input  logic [17:0]       rom_coef1,
  input  logic [17:0]       rom_coef2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ID_W-1:0]   out_id,
  output logic [20:0]       out_coef0,
  output logic [17:0]       out_coef1,
  output logic [17:0]       out_coef2
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_OCC_W = c_CNT_W + 1;

  logic [ID_W-1:0]    r_rr_ptr;
  logic               r_s1_valid;
  logic [ID_W-1:0]    r_s1_id;
  logic               r_s2_valid;
  logic [ID_W-1:0]    r_s2_id;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic [ID_W-1:0]    r_mem_id    [FIFO_DEPTH];
  logic [20:0]        r_mem_coef0 [FIFO_DEPTH];
  logic [17:0]        r_mem_coef1 [FIFO_DEPTH];
  logic [17:0]        r_mem_coef2 [FIFO_DEPTH];

  logic               w_pop;
  logic               w_push;
  logic [c_OCC_W-1:0] w_occ;
  logic               w_credit_ok;
  logic               w_any;
  logic               w_prio_hit;
  logic [ID_W-1:0]    w_win;
  int                 v_idx;

  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid & out_ready;
  assign w_push    = r_s2_valid;

  // Occupancy counts reads still in the tag pipe; a same-cycle pop frees its slot at once.
  assign w_occ = {1'b0, r_count} + c_OCC_W'(r_s1_valid) + c_OCC_W'(r_s2_valid)
               - c_OCC_W'(w_pop);
  assign w_credit_ok = (w_occ < c_OCC_W'(FIFO_DEPTH));

  always_comb begin
    w_any      = 1'b0;
    w_prio_hit = 1'b0;
    w_win      = '0;
    v_idx      = 0;
    if (!rst && w_credit_ok) begin
`ifdef GRNG_COEF_SCHED_PRIO0_EN
      if (req_valid[0]) begin
        w_any      = 1'b1;
        w_prio_hit = 1'b1;
      end
`endif
      for (int k = 0; k < NREQ; k++) begin
        v_idx = (int'(r_rr_ptr) + k) % NREQ;
        if (!w_any && req_valid[v_idx]) begin
          w_any = 1'b1;
          w_win = ID_W'(v_idx);
        end
      end
    end
  end

  assign req_ready = w_any ? (NREQ'(1) << w_win) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      en_coef    <= 1'b0;
      segment    <= '0;
      r_s1_valid <= 1'b0;
      r_s1_id    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_id    <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_id    <= r_s1_id;
      if (w_any) begin
        segment    <= req_seg[7*w_win +: 7];
        en_coef    <= 1'b1;
        r_s1_valid <= 1'b1;
        r_s1_id    <= w_win;
        if (!w_prio_hit)
          r_rr_ptr <= (w_win == ID_W'(NREQ-1)) ? '0 : w_win + ID_W'(1);
      end else begin
        en_coef    <= 1'b0;
        r_s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    end
  end

  // Storage needs no reset: empty entries are masked on the outputs.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_id[r_wr_ptr]    <= r_s2_id;
      r_mem_coef0[r_wr_ptr] <= rom_coef0;
      r_mem_coef1[r_wr_ptr] <= rom_coef1;
      r_mem_coef2[r_wr_ptr] <= rom_coef2;
    end
  end

  assign out_id    = out_valid ? r_mem_id[r_rd_ptr]    : '0;
  assign out_coef0 = out_valid ? r_mem_coef0[r_rd_ptr] : '0;
  assign out_coef1 = out_valid ? r_mem_coef1[r_rd_ptr] : '0;
  assign out_coef2 = out_valid ? r_mem_coef2[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_grng_coef_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_grng_coef_sched: directed bench for grng_coef_sched with a ROM model.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_grng_coef_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [27:0] req_seg;
  logic [3:0]  req_ready;
  logic        en_coef;
  logic [6:0]  segment;
  logic [20:0] rom_coef0;
  logic [17:0] rom_coef1;
  logic [17:0] rom_coef2;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_id;
  logic [20:0] out_coef0;
  logic [17:0] out_coef1;
  logic [17:0] out_coef2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  grng_coef_sched #(.NREQ(4), .ID_W(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_seg(req_seg),
    .req_ready(req_ready), .en_coef(en_coef), .segment(segment),
    .rom_coef0(rom_coef0), .rom_coef1(rom_coef1), .rom_coef2(rom_coef2),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_coef0(out_coef0), .out_coef1(out_coef1), .out_coef2(out_coef2)
  );

  function automatic logic [20:0] m0(input logic [6:0] s);
    logic [20:0] v;
    v = {14'd0, s};
    return v * 21'd9973 + 21'd12345;
  endfunction

  function automatic logic [17:0] m1(input logic [6:0] s);
    logic [17:0] v;
    v = {11'd0, s};
    return (v * 18'd1031) ^ 18'h2A5A5;
  endfunction

  function automatic logic [17:0] m2(input logic [6:0] s);
    return {s, 11'h5A3} ^ 18'h00F0F;
  endfunction

  // Coefficient ROM: registered read, zero output while disabled.
  always_ff @(posedge clk) begin
    if (en_coef) begin
      rom_coef0 <= m0(segment);
      rom_coef1 <= m1(segment);
      rom_coef2 <= m2(segment);
    end else begin
      rom_coef0 <= '0;
      rom_coef1 <= '0;
      rom_coef2 <= '0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    next();
    rst = 1'b0;
  endtask

  task automatic chk_triple(input string tag, input logic [6:0] s);
    chk({tag, "_c0"}, 64'(out_coef0), 64'(m0(s)));
    chk({tag, "_c1"}, 64'(out_coef1), 64'(m1(s)));
    chk({tag, "_c2"}, 64'(out_coef2), 64'(m2(s)));
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'hF;
    req_seg   = {7'd3, 7'd2, 7'd1, 7'd0};
    out_ready = 1'b1;
    next();
    next();
    mid();
    chk("rst_ready", 64'(req_ready), 64'd0);
    next();
    rst = 1'b0;
    req_valid = '0;
    mid();
    chk("rst_en", 64'(en_coef), 64'd0);
    chk("rst_seg", 64'(segment), 64'd0);
    chk("rst_oval", 64'(out_valid), 64'd0);
    chk("rst_oid", 64'(out_id), 64'd0);
    chk("rst_oc0", 64'(out_coef0), 64'd0);

    // Single lookup from requester 2, segment 28.
    next();
    req_valid = 4'b0100;
    req_seg[14 +: 7] = 7'd28;
    mid();
    chk("single_grant", 64'(req_ready), 64'b0100);
    next();
    req_valid = '0;
    mid();
    chk("single_seg", 64'(segment), 64'd28);
    chk("single_en", 64'(en_coef), 64'd1);
    next();
    mid();
    chk("single_en_off", 64'(en_coef), 64'd0);
    chk("single_early", 64'(out_valid), 64'd0);
    next();
    mid();
    chk("single_oval", 64'(out_valid), 64'd1);
    chk("single_oid", 64'(out_id), 64'd2);
    chk_triple("single", 7'd28);
    next();
    mid();
    chk("single_drop", 64'(out_valid), 64'd0);

    // Round robin with all requesters valid.
    next();
    do_reset();
    req_seg = {7'd3, 7'd2, 7'd1, 7'd0};
    for (int c = 0; c < 12; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      mid();
      if (c < 8) chk("rr_grant", 64'(req_ready), 64'(4'b0001 << (c % 4)));
      else       chk("rr_idle", 64'(req_ready), 64'd0);
      if (c >= 1 && c <= 8) begin
        chk("rr_en", 64'(en_coef), 64'd1);
        chk("rr_seg", 64'(segment), 64'((c - 1) % 4));
      end
      if (c == 9) chk("rr_en_off", 64'(en_coef), 64'd0);
      if (c >= 3 && c <= 10) begin
        chk("rr_oval", 64'(out_valid), 64'd1);
        chk("rr_oid", 64'(out_id), 64'((c - 3) % 4));
        chk("rr_oc0", 64'(out_coef0), 64'(m0(7'((c - 3) % 4))));
      end
      if (c == 11) chk("rr_done", 64'(out_valid), 64'd0);
      next();
    end

    // Backpressure: credits cap grants at four until a pop frees one.
    for (int c = 0; c < 15; c++) begin
      out_ready = (c == 8 || c >= 10);
      req_valid = (c < 10) ? 4'hF : 4'h0;
      mid();
      if (c < 4) chk("bp_grant", 64'(req_ready), 64'(4'b0001 << c));
      if (c >= 4 && c <= 7) chk("bp_block", 64'(req_ready), 64'd0);
      if (c == 8) chk("bp_regrant", 64'(req_ready), 64'b0001);
      if (c == 9) chk("bp_block2", 64'(req_ready), 64'd0);
      if (c >= 3 && c <= 8) begin
        chk("bp_hold_val", 64'(out_valid), 64'd1);
        chk("bp_hold_id", 64'(out_id), 64'd0);
        chk("bp_hold_c0", 64'(out_coef0), 64'(m0(7'd0)));
      end
      if (c == 9) chk("bp_next_id", 64'(out_id), 64'd1);
      if (c >= 10 && c <= 13) begin
        chk("bp_drain_val", 64'(out_valid), 64'd1);
        chk("bp_drain_id", 64'(out_id), 64'((c - 9) % 4));
        chk("bp_drain_c0", 64'(out_coef0), 64'(m0(7'((c - 9) % 4))));
      end
      if (c == 14) chk("bp_empty", 64'(out_valid), 64'd0);
      next();
    end

    // Boundary segments 0 and 127 back to back (rr pointer is at 1 here).
    req_seg[7 +: 7]  = 7'd0;
    req_seg[14 +: 7] = 7'd127;
    req_valid = 4'b0010;
    mid();
    chk("bnd_grant1", 64'(req_ready), 64'b0010);
    next();
    req_valid = 4'b0100;
    mid();
    chk("bnd_grant2", 64'(req_ready), 64'b0100);
    chk("bnd_seg0", 64'(segment), 64'd0);
    chk("bnd_en0", 64'(en_coef), 64'd1);
    next();
    req_valid = '0;
    mid();
    chk("bnd_seg127", 64'(segment), 64'd127);
    chk("bnd_en1", 64'(en_coef), 64'd1);
    next();
    mid();
    chk("bnd_idle_en", 64'(en_coef), 64'd0);
    chk("bnd_oid0", 64'(out_id), 64'd1);
    chk_triple("bnd0", 7'd0);
    next();
    mid();
    chk("bnd_oid1", 64'(out_id), 64'd2);
    chk_triple("bnd127", 7'd127);
    next();
    mid();
    chk("bnd_empty", 64'(out_valid), 64'd0);

    // Reset while a read is in flight (rr pointer is at 3 here).
    req_seg = {7'd3, 7'd2, 7'd1, 7'd0};
    next();
    req_valid = 4'b1000;
    mid();
    chk("rmf_grant", 64'(req_ready), 64'b1000);
    next();
    rst = 1'b1;
    req_valid = '0;
    mid();
    chk("rmf_oval1", 64'(out_valid), 64'd0);
    next();
    rst = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      mid();
      chk("rmf_oval", 64'(out_valid), 64'd0);
      if (c == 2) chk("rmf_en", 64'(en_coef), 64'd0);
      next();
    end
    req_valid = 4'hF;
    mid();
    chk("rmf_ptr0", 64'(req_ready), 64'b0001);
    next();
    req_valid = '0;
    next();
    next();
    mid();
    chk("rmf_oval_new", 64'(out_valid), 64'd1);
    chk("rmf_oid_new", 64'(out_id), 64'd0);
    chk_triple("rmf", 7'd0);
    next();

`ifdef GRNG_COEF_SCHED_PRIO0_EN
    req_valid = 4'b0011;
    for (int c = 0; c < 6; c++) begin
      mid();
      chk("prio_grant0", 64'(req_ready), 64'b0001);
      next();
    end
    req_valid = 4'b0010;
    mid();
    chk("prio_grant1", 64'(req_ready), 64'b0010);
    next();
    req_valid = '0;
    for (int c = 0; c < 5; c++) next();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/grng_coef_sched.md
Name: grng_coef_sched

Overview:
- Round-robin scheduler sharing one coefficient ROM (128 segments; coef0 21b, coef1 18b, coef2 18b; 1-cycle registered read, outputs zeroed when enable low) between NREQ ICDF channel datapaths.
- Accepts segment lookup requests, drives ROM enable/segment, tracks in-flight reads with requester tags.
- Buffers returned coefficient triples in an output FIFO with ready/valid backpressure, using credit-based issue so no ROM read is ever lost.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, requester tag width, ceil(log2(NREQ)), minimum 1.
- FIFO_DEPTH, 4, output buffer entries (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester lookup request.
- req_seg  in  7*NREQ  segment for requester i at bits [7i+6:7i].
- req_ready  out  NREQ  one-hot grant. Combinational; handshake on req_valid[i]&req_ready[i].
- en_coef  out  1  ROM enable, registered.
- segment  out  7  ROM segment, registered.
- rom_coef0  in  21  ROM coef0 output.
- rom_coef1  in  18  ROM coef1 output.
- rom_coef2  in  18  ROM coef2 output.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accept.
- out_id  out  ID_W  requester tag of head entry.
- out_coef0  out  21  head coef0.
- out_coef1  out  18  head coef1.
- out_coef2  out  18  head coef2.

Behaviour:
- Reset (sync):
  - en_coef=0, segment=0, in-flight pipe cleared, FIFO empty, out_valid=0, out_id/out_coef*=0, rr pointer=0.
  - req_ready=0 while rst high.
  - Reset mid-operation discards in-flight reads and buffered entries; nothing is emitted after reset releases.
- Credit:
  - credit_ok = (fifo_count + inflight) < FIFO_DEPTH, where inflight = valid bits in the 2-stage tag pipe.
  - No grant while credit_ok=0.
- Arbitration (cycle T):
  - If credit_ok and any req_valid, grant the first valid requester scanning from rr_ptr upward, with wrap.
  - req_ready is one-hot to the winner; all zeros otherwise.
  - On grant, rr_ptr <= winner+1 mod NREQ. With no grant, rr_ptr holds.
  - Non-winning requesters must hold req_valid and req_seg; no timeout.
- Issue pipeline:
  - End of T: segment<=winner seg, en_coef<=1, tag stage1 <= {1, winner id}.
  - With no grant: en_coef<=0, segment holds, stage1 valid<=0.
  - End of T+1: ROM registers coefs; stage2<=stage1.
  - End of T+2: if stage2 valid, write {id, rom_coef0/1/2} to FIFO.
  - out_valid rises at T+3. Fixed accept-to-output latency is 3 cycles when the FIFO is empty.
  - Back-to-back grants give one issue per cycle; throughput is 1/cycle while out_ready=1.
- FIFO:
  - Circular buffer with head/tail pointers and count of width log2(FIFO_DEPTH)+1.
  - Pop on out_valid&out_ready. Simultaneous push and pop keeps count unchanged. Push to full cannot occur by credit construction.
  - Outputs are driven from the head entry and held stable while out_valid&~out_ready.
  - Pointers wrap at FIFO_DEPTH.
- Credit timing: a pop frees a credit in the same cycle (count decrement is visible combinationally to credit_ok).
- Zero ROM data when en_coef=0 is never captured, because stage2 is invalid in that case.

Optional Feature:
- Macro GRNG_COEF_SCHED_PRIO0_EN.
- Defined: requester 0 has strict priority. When req_valid[0] and credit_ok, grant 0 and do not update rr_ptr. The remaining requesters are round-robin among themselves when req_valid[0]=0.
- Undefined: pure round-robin over all NREQ requesters as above.

Test Plan:
- Single lookup: reset, then req_valid=4'b0100, seg2=7'd28 at T, out_ready=1 → req_ready=4'b0100 at T; segment=28, en_coef=1 at T+1; out_valid=1, out_id=2 at T+3; out_coef0/1/2 equal ROM model entry 28; out_valid=0 at T+4.
- Round-robin fairness: all four requesters valid continuously, segs 0/1/2/3, out_ready=1 → grants 0,1,2,3,0,… one per cycle; out_id sequence 0,1,2,3 starting T+3; 100% ROM duty.
- Backpressure/credit: all valid, out_ready=0 → exactly 4 grants, then req_ready=0. FIFO holds ids 0..3 stable. Raise out_ready for 1 cycle → one pop and one new grant that same cycle; no entry lost or duplicated.
- Boundary segments: lookups for seg 0 and seg 127 back-to-back → both triples match the ROM model; en_coef is 0 in the idle cycle afterward.
- Reset mid-flight: grant at T, rst=1 at T+1 → out_valid stays 0 through T+5; rr_ptr=0; the next request issues normally.
- With GRNG_COEF_SCHED_PRIO0_EN: requesters 0 and 1 always valid → only requester 0 is granted. Drop req_valid[0] → requester 1 is granted the next cycle.
